// File: rtl/delay_mem_pkg.sv
// Shared requester indices, request-vector type and read-latency bounds for the delay-line RAM arbiter.
// No logic of its own, so it adds no latency.
// No backpressure; holds only constants and types.
package delay_mem_pkg;

   localparam int REQ_MAIN = 0;
   localparam int REQ_CHOR = 1;
   localparam int REQ_REV  = 2;
   localparam int N_REQ    = 3;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef logic [N_REQ-1:0] req_vec_t;

   function automatic bit rd_lat_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one of N_REQ read requesters: round-robin with ARB_ROUND_ROBIN_EN, else fixed reverb > chorus > main.
// The select is combinational; the round-robin pointer updates on the clock edge.
// No backpressure; the caller masks requests and gates pointer advance through adv.
module rr_arbiter
   import delay_mem_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic             clk,
   input  logic             reset,
   input  logic             adv,
`endif
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
   // One-hot copy of the last read winner; the search starts just after it.
   req_vec_t ptr;
   logic     found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && ptr[j] && req[(j + i) % N_REQ]) begin
               gnt[(j + i) % N_REQ] = 1'b1;
               found                = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= req_vec_t'(1) << REQ_MAIN;
      else if (adv && (|gnt))
         ptr <= gnt;
   end
`else
   always_comb begin
      gnt = '0;
      if (req[REQ_REV])
         gnt[REQ_REV] = 1'b1;
      else if (req[REQ_CHOR])
         gnt[REQ_CHOR] = 1'b1;
      else if (req[REQ_MAIN])
         gnt[REQ_MAIN] = 1'b1;
   end
`endif

endmodule

// File: rtl/delay_mem_arbiter.sv
// Shares one single-port delay-line RAM between the sample writer and three readers (ARB_ROUND_ROBIN_EN selects read policy).
// Issue one cycle after request; read data and one-hot tag return RD_LAT+1 cycles after issue.
// Requesters hold until gnt/ack; a granted requester is masked for one cycle, and writes always beat reads.
module delay_mem_arbiter
   import delay_mem_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic [2:0]        rd_req,
   input  logic [ADDR_W-1:0] rd_addr_main,
   input  logic [ADDR_W-1:0] rd_addr_chor,
   input  logic [ADDR_W-1:0] rd_addr_rev,
   output logic [2:0]        rd_gnt,
   output logic [2:0]        rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("delay_mem_arbiter: RD_LAT must be 1 or 2");
   end

   logic              wr_eff;
   req_vec_t          rd_eff;
   req_vec_t          arb_gnt;
   logic [ADDR_W-1:0] rd_addr_sel;
   req_vec_t          pipe [RD_LAT+1];
   logic              busy_c;

   // Whoever was granted this cycle sits out the next edge.
   assign wr_eff = wr_req & ~wr_ack;
   assign rd_eff = rd_req & ~rd_gnt;

   rr_arbiter u_arb (
`ifdef ARB_ROUND_ROBIN_EN
      .clk   (clk),
      .reset (reset),
      .adv   (!wr_eff),
`endif
      .req   (rd_eff),
      .gnt   (arb_gnt)
   );

   always_comb begin
      rd_addr_sel = '0;
      if (arb_gnt[REQ_MAIN])
         rd_addr_sel = rd_addr_main;
      else if (arb_gnt[REQ_CHOR])
         rd_addr_sel = rd_addr_chor;
      else if (arb_gnt[REQ_REV])
         rd_addr_sel = rd_addr_rev;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ack    <= 1'b0;
         rd_gnt    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_data   <= '0;
         for (int i = 0; i <= RD_LAT; i++)
            pipe[i] <= '0;
      end else begin
         wr_ack    <= wr_eff;
         rd_gnt    <= wr_eff ? '0 : arb_gnt;
         mem_en    <= wr_eff | (|arb_gnt);
         mem_we    <= wr_eff;
         mem_addr  <= wr_eff ? wr_addr : rd_addr_sel;
         mem_wdata <= wr_eff ? wr_data : '0;
         pipe[0]   <= rd_gnt;
         for (int i = 1; i <= RD_LAT; i++)
            pipe[i] <= pipe[i-1];
         // mem_rdata is valid while the tag sits one stage before the output.
         if (|pipe[RD_LAT-1])
            rd_data <= mem_rdata;
      end
   end

   always_comb begin
      busy_c = |rd_gnt;
      for (int i = 0; i <= RD_LAT; i++)
         busy_c = busy_c | (|pipe[i]);
   end

   assign rd_valid = pipe[RD_LAT];
   assign busy     = busy_c;

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Directed vector table plus reset sequences for delay_mem_arbiter at RD_LAT=1.
module tb_delay_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_req;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [2:0]  rd_req;
   logic [11:0] rd_addr_main;
   logic [11:0] rd_addr_chor;
   logic [11:0] rd_addr_rev;
   logic [2:0]  rd_gnt;
   logic [2:0]  rd_valid;
   logic [15:0] rd_data;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   delay_mem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .rd_req       (rd_req),
      .rd_addr_main (rd_addr_main),
      .rd_addr_chor (rd_addr_chor),
      .rd_addr_rev  (rd_addr_rev),
      .rd_gnt       (rd_gnt),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .busy         (busy)
   );

   localparam logic [11:0] A_MAIN = 12'h123;
   localparam logic [11:0] A_CHOR = 12'h2C0;
   localparam logic [11:0] A_REV  = 12'h3A5;

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic [2:0] G15 = 3'b100, G16 = 3'b001, G17 = 3'b010, G18 = 3'b100, G_RST = 3'b010;
`else
   localparam logic [2:0] G15 = 3'b100, G16 = 3'b010, G17 = 3'b100, G18 = 3'b010, G_RST = 3'b100;
`endif

   typedef struct {
      logic        wr;
      logic [11:0] wa;
      logic [15:0] wd;
      logic [2:0]  rr;
      logic [15:0] mrd;
      logic        e_ack;
      logic [2:0]  e_gnt;
      logic [2:0]  e_val;
      logic [15:0] e_data;
      logic        e_en;
      logic        e_we;
      logic [11:0] e_addr;
      logic [15:0] e_wdata;
      logic        e_busy;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic wr, input logic [11:0] wa, input logic [15:0] wd,
                               input logic [2:0] rr, input logic [15:0] mrd,
                               input logic e_ack, input logic [2:0] e_gnt, input logic [2:0] e_val,
                               input logic [15:0] e_data, input logic e_en, input logic e_we,
                               input logic [11:0] e_addr, input logic [15:0] e_wdata, input logic e_busy);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.rr = rr; v.mrd = mrd;
      v.e_ack = e_ack; v.e_gnt = e_gnt; v.e_val = e_val; v.e_data = e_data;
      v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_busy = e_busy;
      return v;
   endfunction

   function automatic logic [11:0] addr_of(input logic [2:0] g);
      case (g)
         3'b001:  return A_MAIN;
         3'b010:  return A_CHOR;
         3'b100:  return A_REV;
         default: return 12'h000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wr_ack"},    32'(wr_ack),    32'h0);
      chk({tag, " rd_gnt"},    32'(rd_gnt),    32'h0);
      chk({tag, " rd_valid"},  32'(rd_valid),  32'h0);
      chk({tag, " rd_data"},   32'(rd_data),   32'h0);
      chk({tag, " mem_en"},    32'(mem_en),    32'h0);
      chk({tag, " mem_we"},    32'(mem_we),    32'h0);
      chk({tag, " mem_addr"},  32'(mem_addr),  32'h0);
      chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, " busy"},      32'(busy),      32'h0);
   endtask

   initial begin
      reset        = 1'b1;
      wr_req       = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      rd_req       = '0;
      rd_addr_main = A_MAIN;
      rd_addr_chor = A_CHOR;
      rd_addr_rev  = A_REV;
      mem_rdata    = '0;

      //          wr  wa      wd        rr      mrd       ack gnt     val     data      en we addr         wdata     busy
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b001, 16'h0,    0, 3'b001, 3'b000, 16'h0,    1, 0, A_MAIN,      16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0,    0, 3'b000, 3'b000, 16'h0,    0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'hBEEF, 0, 3'b000, 3'b001, 16'hBEEF, 0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h1111, 0, 3'b000, 3'b000, 16'hBEEF, 0, 0, 12'h0,       16'h0,    0));
      vt.push_back(mk(1, 12'h010,16'h55AA, 3'b100, 16'h0,    1, 3'b000, 3'b000, 16'hBEEF, 1, 1, 12'h010,     16'h55AA, 0));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b100, 16'h0,    0, 3'b100, 3'b000, 16'hBEEF, 1, 0, A_REV,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b010, 16'h0,    0, 3'b010, 3'b000, 16'hBEEF, 1, 0, A_CHOR,      16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'hA001, 0, 3'b000, 3'b100, 16'hA001, 0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'hC002, 0, 3'b000, 3'b010, 16'hC002, 0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0,    0, 3'b000, 3'b000, 16'hC002, 0, 0, 12'h0,       16'h0,    0));
      vt.push_back(mk(1, 12'h7FF,16'h1234, 3'b000, 16'h0,    1, 3'b000, 3'b000, 16'hC002, 1, 1, 12'h7FF,     16'h1234, 0));
      vt.push_back(mk(1, 12'h7FF,16'h1234, 3'b000, 16'h0,    0, 3'b000, 3'b000, 16'hC002, 0, 0, 12'h0,       16'h0,    0));
      vt.push_back(mk(1, 12'h7FF,16'h1234, 3'b000, 16'h0,    1, 3'b000, 3'b000, 16'hC002, 1, 1, 12'h7FF,     16'h1234, 0));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0,    0, 3'b000, 3'b000, 16'hC002, 0, 0, 12'h0,       16'h0,    0));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b111, 16'h0,    0, G15,    3'b000, 16'hC002, 1, 0, addr_of(G15), 16'h0,   1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b111, 16'h0,    0, G16,    3'b000, 16'hC002, 1, 0, addr_of(G16), 16'h0,   1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b111, 16'h0A0A, 0, G17,    G15,    16'h0A0A, 1, 0, addr_of(G17), 16'h0,   1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b111, 16'h0B0B, 0, G18,    G16,    16'h0B0B, 1, 0, addr_of(G18), 16'h0,   1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0C0C, 0, 3'b000, G17,    16'h0C0C, 0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0D0D, 0, 3'b000, G18,    16'h0D0D, 0, 0, 12'h0,       16'h0,    1));
      vt.push_back(mk(0, 12'h0,  16'h0,    3'b000, 16'h0E0E, 0, 3'b000, 3'b000, 16'h0D0D, 0, 0, 12'h0,       16'h0,    0));

      // Reset values while reset is held.
      #12;
      chk_all_zero("reset_state");
      @(negedge clk);
      reset = 1'b0;

      foreach (vt[k]) begin
         wr_req    = vt[k].wr;
         wr_addr   = vt[k].wa;
         wr_data   = vt[k].wd;
         rd_req    = vt[k].rr;
         mem_rdata = vt[k].mrd;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d wr_ack", k),    32'(wr_ack),    32'(vt[k].e_ack));
         chk($sformatf("row%0d rd_gnt", k),    32'(rd_gnt),    32'(vt[k].e_gnt));
         chk($sformatf("row%0d rd_valid", k),  32'(rd_valid),  32'(vt[k].e_val));
         chk($sformatf("row%0d rd_data", k),   32'(rd_data),   32'(vt[k].e_data));
         chk($sformatf("row%0d mem_en", k),    32'(mem_en),    32'(vt[k].e_en));
         chk($sformatf("row%0d mem_we", k),    32'(mem_we),    32'(vt[k].e_we));
         chk($sformatf("row%0d mem_addr", k),  32'(mem_addr),  32'(vt[k].e_addr));
         chk($sformatf("row%0d mem_wdata", k), 32'(mem_wdata), 32'(vt[k].e_wdata));
         chk($sformatf("row%0d busy", k),      32'(busy),      32'(vt[k].e_busy));
      end

      // Async reset one cycle after a read grant discards the in-flight tag.
      wr_req = 1'b0;
      rd_req = 3'b001;
      @(posedge clk);
      #1;
      chk("midrst grant", 32'(rd_gnt), 32'h1);
      rd_req    = 3'b000;
      mem_rdata = 16'hFACE;
      @(posedge clk);
      #2;
      chk("midrst busy_before", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      chk_all_zero("midrst async");
      #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("midrst cyc%0d rd_valid", c), 32'(rd_valid), 32'h0);
         chk($sformatf("midrst cyc%0d busy", c),     32'(busy),     32'h0);
      end

      // Arbitration state restarts from reset.
      rd_req = 3'b111;
      @(posedge clk);
      #1;
      chk("post_reset first grant", 32'(rd_gnt), 32'(G_RST));
      rd_req = 3'b000;
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
